// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder: {cout,sum} = a + b + cin, one SEG-bit segment per stage (NSEG = WIDTH/SEG); optional ovf under CSA_OVERFLOW_FLAG_EN.
// Latency: result valid NSEG-1 cycles after the accepting edge (registered once when NSEG = 1).
// Backpressure: in_ready = !(out_valid && !out_ready); every stage, including the output, holds while stalled.
module pipelined_carry_select_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = WIDTH / SEG;

    // Each stage carries the full operands forward (input skew) and the
    // partially built sum (output de-skew), so a transaction stays aligned.
    typedef struct packed {
        logic             vld;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t         src     [NSEG];
    stage_t         stage_d [NSEG];
    stage_t         stage_q [NSEG];
    logic           adv;
    logic [SEG-1:0] seg_a;
    logic [SEG-1:0] seg_b;
    logic [SEG:0]   cand0;
    logic [SEG:0]   cand1;
    logic [SEG:0]   pick;

    always_comb begin
        adv        = !(stage_q[NSEG-1].vld && !out_ready);
        src[0].vld = in_valid;
        src[0].c   = cin;
        src[0].a   = a;
        src[0].b   = b;
        src[0].s   = '0;
        for (int k = 1; k < NSEG; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    always_comb begin
        seg_a = '0;
        seg_b = '0;
        cand0 = '0;
        cand1 = '0;
        pick  = '0;
        for (int k = 0; k < NSEG; k++) begin
            stage_d[k] = stage_q[k];
            seg_a      = src[k].a[k*SEG +: SEG];
            seg_b      = src[k].b[k*SEG +: SEG];
            cand0      = {1'b0, seg_a} + {1'b0, seg_b};
            cand1      = {1'b0, seg_a} + {1'b0, seg_b} + (SEG+1)'(1);
            pick       = src[k].c ? cand1 : cand0;
            if (adv) begin
                stage_d[k].vld = src[k].vld;
                if (src[k].vld) begin
                    stage_d[k].c                  = pick[SEG];
                    stage_d[k].a                  = src[k].a;
                    stage_d[k].b                  = src[k].b;
                    stage_d[k].s                  = src[k].s;
                    stage_d[k].s[k*SEG +: SEG]    = pick[SEG-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // The last stage's operand copies have no consumer downstream.
    logic unused_top_operands;
    assign unused_top_operands = ^{stage_q[NSEG-1].a, stage_q[NSEG-1].b};

    assign in_ready  = adv;
    assign out_valid = stage_q[NSEG-1].vld;
    assign sum       = stage_q[NSEG-1].s;
    assign cout      = stage_q[NSEG-1].c;

`ifdef CSA_OVERFLOW_FLAG_EN
    logic ovf_d;
    logic ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (adv && src[NSEG-1].vld) begin
            ovf_d = (src[NSEG-1].a[WIDTH-1] == src[NSEG-1].b[WIDTH-1]) &&
                    (stage_d[NSEG-1].s[WIDTH-1] != src[NSEG-1].a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/pipelined_carry_select_adder.md
# pipelined_carry_select_adder

Parametrised, pipelined carry-select adder: the next generation of the fixed 16-bit carry-select adder. It adds two WIDTH-bit operands plus carry-in, split into SEG-bit segments with one pipeline register per segment. Operands enter and results leave through valid/ready handshakes. It sits on datapaths that need a full-width sum every cycle at a clock rate a single-cycle ripple of carry-select blocks cannot meet.

## Interface
- WIDTH, 32, operand and sum width; must be a multiple of SEG.
- SEG, 8, segment width. NSEG = WIDTH/SEG pipeline stages, with NSEG ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to segment 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry-out of the top segment.
- ovf  output  1  signed overflow. Present only with CSA_OVERFLOW_FLAG_EN.

## Operation
- Stage k (k = 0..NSEG-1) handles operand bits [k·SEG +: SEG].
- Each stage computes two candidate results: the segment sum with carry 0 and with carry 1. It selects one using the registered carry from stage k-1. Stage 0 uses cin.
- Operand slices for segment k are delayed k cycles (input skew). Completed low segments are delayed (NSEG-1-k) cycles (output de-skew), so all segments of one transaction emerge together.
- Each stage has a valid bit; bubbles propagate as invalid stages.
- The pipeline advances when adv = !(out_valid && !out_ready).
  - in_ready = adv.
  - A transfer occurs when in_valid && in_ready.
  - On a stall every stage register holds, including the final output.
- Arithmetic is unsigned modulo 2^WIDTH.
  - cout is the carry out of bit WIDTH-1.
  - {cout, sum} equals the WIDTH+1-bit exact sum a + b + cin.
- Transactions complete strictly in order, with no reordering or dropping.
- Reset (asserted at any time, including mid-stream) clears all valid bits, sum, cout and ovf asynchronously. In-flight transactions are discarded, not completed.

## Timing
- Reset values: out_valid = 0, sum = 0, cout = 0, ovf = 0.
- in_ready is 1 in the first cycle after rst_n deasserts.
- Latency: a transaction accepted at clock edge t produces out_valid = 1 after edge t+NSEG-1.
  - With NSEG = 1 the result is registered once: out_valid rises the cycle after acceptance.
- Throughput: one transaction per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready and out_valid only. It does not depend on in_valid.
- While out_valid && !out_ready, sum, cout and ovf are stable and in_ready = 0.
- Simultaneous out transfer and in transfer in the same cycle is legal; nothing is lost.
- in_valid may drop at any time. The resulting bubble appears as out_valid = 0 NSEG cycles later.
- Operand changes while in_valid = 0 or in_ready = 0 are ignored.

## Configuration
- Macro: CSA_OVERFLOW_FLAG_EN.
- Defined:
  - Port ovf exists and is aligned with sum and cout.
  - ovf = 1 when a and b have the same MSB and sum's MSB differs from it (two's-complement overflow, including the cin contribution).
  - ovf is held during stalls and reset to 0.
- Undefined: port ovf and its pipeline bits are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH = 16, SEG = 4 (NSEG = 4).
- Basic adds, out_ready = 1: a=4, b=3, cin=0 -> sum=7, cout=0; then a=5, b=6, cin=1 -> sum=12, cout=0. Each out_valid appears 3 cycles after the accepting edge.
- Wrap-around: a=16'hFFFF, b=1, cin=0 -> sum=0, cout=1. Also a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1. This exercises carry-select across all segments.
- Streaming: 100 back-to-back random transactions with out_ready = 1 -> one result per cycle, in order, each matching the reference {cout, sum}.
- Backpressure: random in_valid and out_ready patterns -> in_ready = 0 exactly when out_valid && !out_ready. No result is dropped or duplicated, and sum is stable during stalls.
- Reset mid-flight: accept 3 transactions, assert rst_n = 0 for one cycle -> out_valid = 0, sum = 0, cout = 0 immediately (asynchronous). None of the 3 results ever appear, and in_ready = 1 after release.
- With CSA_OVERFLOW_FLAG_EN defined:
  - a=16'h7FFF, b=1, cin=0 -> sum=16'h8000, ovf=1, cout=0.
  - a=16'h8000, b=16'h8000 -> sum=0, ovf=1, cout=1.
  - a=5, b=3 -> ovf=0.
